io_out_fifo: RTL and testbench
==============================

Name: io_out_fifo

Overview:
- Sits directly downstream of the processor core's output interface.
- Captures each OUT write from the core (out_en, addr_out, data_out) into a small FIFO.
- Presents the queued entries to external peripherals over a valid/ready handshake.
- Decouples the non-stallable core from slow output consumers and flags lost writes.

Parameters:
NUBITS, 32, data word width (matches core data path)
NUIOOU, 8, number of output port addresses; address width AW = $clog2(NUIOOU), minimum 1
FDEPTH, 4, FIFO depth in entries; power of two, minimum 2
CNTW, 16, timestamp counter width (used only with the optional feature)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous reset, active-low (0 = reset)
out_en  input  1  core output strobe; one write per cycle when high
addr_out  input  AW  core output port address
data_out  input  NUBITS  core output data
m_valid  output  1  head entry available
m_ready  input  1  consumer accepts head entry
m_addr  output  AW  port address of head entry
m_data  output  NUBITS  data of head entry
level  output  $clog2(FDEPTH)+1  current number of stored entries
full  output  1  level == FDEPTH
ovf  output  1  sticky overflow flag
ovf_clr  input  1  clears ovf

Behaviour:
- Reset (rst low, asynchronous):
  - Read/write pointers, level, ovf and the timestamp counter go to 0.
  - m_valid = 0 and full = 0 immediately; m_addr/m_data = 0.
  - Stored contents are discarded.
  - Reset asserted mid-transfer drops everything; no partial state survives.
- Push:
  - out_en high at a rising edge with the FIFO not full writes {addr_out, data_out} at wr_ptr.
  - wr_ptr advances modulo FDEPTH; pointers carry one extra wrap bit for full/empty.
- Pop:
  - m_valid && m_ready at a rising edge advances rd_ptr modulo FDEPTH.
  - m_ready with m_valid low has no effect.
- Latency:
  - A push into an empty FIFO asserts m_valid on the next cycle. There is no combinational fall-through from out_en to m_valid.
  - m_addr/m_data reflect the head entry from the storage array and are stable while m_valid is high and m_ready is low.
- Simultaneous push and pop:
  - Not full: both occur, level unchanged.
  - Full with pop: the push is accepted into the freed slot, level stays FDEPTH, no overflow.
  - Empty: only the push takes effect, since m_valid is low.
- Overflow:
  - out_en while full and no pop in the same cycle drops the write; storage and pointers are unchanged.
  - ovf is set on the next edge.
  - ovf stays high until ovf_clr is sampled high; if set and clear occur in the same cycle, set wins.
- Handshake rule: once m_valid is high, it stays high until the entry is popped or reset occurs.
- Outputs: level, full and m_valid are registered or derived from registered pointers only; there is no combinational path from out_en or m_ready to any output.
- Wrap-around: pointer increment past FDEPTH-1 returns to 0 and toggles the wrap bit.
  - full = (addresses equal, wrap bits differ).
  - empty = (pointers equal).

Optional Feature:
Macro IO_OUT_TIMESTAMP_EN.
- Defined:
  - A CNTW-bit free-running cycle counter (reset 0, wraps to 0) is stored with each pushed entry.
  - The stored value is the counter at the push edge.
  - It is presented on an extra output m_tstamp [CNTW-1:0], aligned with m_data; m_tstamp = 0 in reset.
- Not defined:
  - There is no counter, no m_tstamp port and no extra storage width.
  - All other behaviour is identical.

Decomposition:
- Shared include header holds:
  - the entry-width calculation (AW + NUBITS, + CNTW when timestamping),
  - the pointer-width rule ($clog2(FDEPTH)+1),
  - the IO_OUT_TIMESTAMP_EN default (undefined).
- One sub-module, io_fifo_mem:
  - parameterised width/depth register array with synchronous write and asynchronous read by address.
  - Pointer, flag and overflow logic stays in io_out_fifo.

Test Plan:
- Reset then idle: rst low 3 cycles, release -> m_valid=0, level=0, full=0, ovf=0; m_ready toggling causes no change.
- Single write: out_en=1, addr_out=3, data_out=0x0000ABCD for one cycle, m_ready=0 -> next cycle m_valid=1, m_addr=3, m_data=0xABCD, level=1; m_ready=1 one cycle -> m_valid=0, level=0.
- Fill and overflow (FDEPTH=4): push data 1..5 on consecutive cycles, m_ready=0 -> level=4, full=1, ovf=1 after fifth; popping yields 1,2,3,4 in order, 5 never appears; ovf_clr pulse -> ovf=0.
- Full with simultaneous push/pop: FIFO holds 1..4, cycle with out_en=1 (data 9) and m_ready=1 -> ovf stays 0, level=4; subsequent pops yield 2,3,4,9.
- Wrap-around streaming: m_ready=1 constantly, 20 consecutive pushes 0..19 -> outputs 0..19 in order, each one cycle after push, level never exceeds 1.
- Reset mid-operation: 3 entries stored, rst low asynchronously between edges -> m_valid and level drop to 0 immediately; after release, a new push of 0x55 emerges as the first entry.

Source files
------------

// File: rtl/io_out_fifo_pkg.sv
// Shared sizing rules for the core output FIFO: address, pointer and entry widths.
// No logic; elaboration-time helpers only.
// Optional macro IO_OUT_TIMESTAMP_EN (undefined by default) widens each entry by CNTW bits.
package io_out_fifo_pkg;

  // Port address width, never below one bit even for a single output port
  function automatic int addr_width(input int nuioou);
    return ($clog2(nuioou) < 1) ? 1 : $clog2(nuioou);
  endfunction

  // Pointers carry one extra wrap bit so full and empty can be told apart
  function automatic int ptr_width(input int fdepth);
    return $clog2(fdepth) + 1;
  endfunction

  // Stored entry: {[timestamp,] addr, data}
  function automatic int entry_width(input int aw, input int nubits, input int cntw);
`ifdef IO_OUT_TIMESTAMP_EN
    return aw + nubits + cntw;
`else
    return aw + nubits + (cntw * 0);
`endif
  endfunction

endpackage

// File: rtl/io_out_fifo_mem.sv
// Register array for FIFO storage: synchronous write, asynchronous read by address.
// Read data is combinational from the array; a write is visible after the clock edge.
// No backpressure; the caller decides when to write.
module io_fifo_mem #(
  parameter int W = 35,
  parameter int D = 4
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [$clog2(D)-1:0] waddr,
  input  logic [W-1:0]         wdata,
  input  logic [$clog2(D)-1:0] raddr,
  output logic [W-1:0]         rdata
);

  logic [W-1:0] mem [D];

  // Contents need no reset: the FIFO never presents a slot it has not written
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/io_out_fifo.sv
// Queues core OUT writes and hands them to peripherals over valid/ready; flags dropped writes.
// Latency: a push into an empty FIFO shows m_valid on the next cycle (no fall-through).
// Backpressure: the core cannot stall, so writes while full without a pop are dropped and set ovf.
// Optional macro IO_OUT_TIMESTAMP_EN adds a free-running counter captured per entry on m_tstamp.
module io_out_fifo
  import io_out_fifo_pkg::*;
#(
  parameter int NUBITS = 32,
  parameter int NUIOOU = 8,
  parameter int FDEPTH = 4,
  parameter int CNTW   = 16
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            out_en,
  input  logic [addr_width(NUIOOU)-1:0]   addr_out,
  input  logic [NUBITS-1:0]               data_out,
  output logic                            m_valid,
  input  logic                            m_ready,
  output logic [addr_width(NUIOOU)-1:0]   m_addr,
  output logic [NUBITS-1:0]               m_data,
  output logic [ptr_width(FDEPTH)-1:0]    level,
  output logic                            full,
  output logic                            ovf,
  input  logic                            ovf_clr
`ifdef IO_OUT_TIMESTAMP_EN
  ,
  output logic [CNTW-1:0]                 m_tstamp
`endif
);

  localparam int AW = addr_width(NUIOOU);
  localparam int PW = ptr_width(FDEPTH);
  localparam int IW = PW - 1;
  localparam int EW = entry_width(AW, NUBITS, CNTW);

  logic [PW-1:0] wr_ptr, rd_ptr;
  logic          empty, pop, push, ovf_set;
  logic [EW-1:0] wr_ent, rd_ent;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[IW-1:0] == rd_ptr[IW-1:0]) && (wr_ptr[IW] != rd_ptr[IW]);
  assign m_valid = !empty;
  assign level   = wr_ptr - rd_ptr;

  // A pop in the same cycle frees a slot, so a write while full is still accepted
  assign pop     = m_valid && m_ready;
  assign push    = out_en && (!full || pop);
  assign ovf_set = out_en && full && !pop;

`ifdef IO_OUT_TIMESTAMP_EN
  logic [CNTW-1:0] ts_cnt;

  // Free-running cycle counter sampled into each entry at its push edge
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) ts_cnt <= '0;
    else      ts_cnt <= ts_cnt + CNTW'(1);
  end

  assign wr_ent   = {ts_cnt, addr_out, data_out};
  assign m_tstamp = m_valid ? rd_ent[EW-1 -: CNTW] : '0;
`else
  assign wr_ent   = {addr_out, data_out};
`endif

  // Head fields read zero whenever nothing is queued, including during reset
  assign m_addr = m_valid ? rd_ent[NUBITS +: AW] : '0;
  assign m_data = m_valid ? rd_ent[NUBITS-1:0]   : '0;

  // Pointer advance; the extra top bit toggles on each wrap past FDEPTH-1
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
    end
  end

  // Sticky overflow; a new drop in the same cycle as a clear keeps the flag set
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)         ovf <= 1'b0;
    else if (ovf_set) ovf <= 1'b1;
    else if (ovf_clr) ovf <= 1'b0;
  end

  io_fifo_mem #(
    .W (EW),
    .D (FDEPTH)
  ) u_mem (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr[IW-1:0]),
    .wdata (wr_ent),
    .raddr (rd_ptr[IW-1:0]),
    .rdata (rd_ent)
  );

endmodule

// File: tb/tb_io_out_fifo.sv
// Self-checking bench for io_out_fifo: directed scenarios plus randomized traffic vs a queue model.
// Outputs are sampled 1 time unit after each rising edge; inputs change at that point too.
// The model is a bounded queue with a sticky overflow bit, reset whenever rst is driven low.
module tb_io_out_fifo;

  localparam int NB = 32;
  localparam int AW = 3;
  localparam int FD = 4;
  localparam int LW = 3;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          out_en;
  logic [AW-1:0] addr_out;
  logic [NB-1:0] data_out;
  logic          m_valid;
  logic          m_ready;
  logic [AW-1:0] m_addr;
  logic [NB-1:0] m_data;
  logic [LW-1:0] level;
  logic          full;
  logic          ovf;
  logic          ovf_clr;
`ifdef IO_OUT_TIMESTAMP_EN
  logic [CW-1:0] m_tstamp;
`endif

  int checks = 0;
  int errors = 0;

  logic [AW+NB-1:0] mq[$];
  bit               m_ovf;

  always #5 clk = ~clk;

  io_out_fifo #(.NUBITS(NB), .NUIOOU(8), .FDEPTH(FD), .CNTW(CW)) dut (
    .clk      (clk),
    .rst      (rst),
    .out_en   (out_en),
    .addr_out (addr_out),
    .data_out (data_out),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .m_addr   (m_addr),
    .m_data   (m_data),
    .level    (level),
    .full     (full),
    .ovf      (ovf),
    .ovf_clr  (ovf_clr)
`ifdef IO_OUT_TIMESTAMP_EN
    ,
    .m_tstamp (m_tstamp)
`endif
  );

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  task automatic model_reset();
    mq.delete();
    m_ovf = 0;
  endtask

  // Advance one clock edge; the model applies the same edge using the inputs held across it
  task automatic cyc();
    int  sz;
    bit  pop, acc, set;
    @(posedge clk);
    if (rst) begin
      sz  = mq.size();
      pop = (sz > 0) && m_ready;
      acc = out_en && ((sz < FD) || pop);
      set = out_en && (sz == FD) && !pop;
      if (pop) void'(mq.pop_front());
      if (acc) mq.push_back({addr_out, data_out});
      if (set) m_ovf = 1;
      else if (ovf_clr) m_ovf = 0;
    end
    #1;
  endtask

  task automatic idle_inputs();
    out_en = 0; addr_out = '0; data_out = '0; m_ready = 0; ovf_clr = 0;
  endtask

  task automatic push_one(input logic [AW-1:0] a, input logic [NB-1:0] d);
    out_en = 1; addr_out = a; data_out = d;
    cyc();
    out_en = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 0;
    model_reset();
    repeat (3) cyc();
    checks++;
    if (m_valid !== 1'b0 || level !== '0 || full !== 1'b0 || ovf !== 1'b0 || m_addr !== '0 || m_data !== '0) begin
      errors++;
      $display("FAIL reset_state: got valid=%b level=%0d full=%b ovf=%b addr=%0d data=%h, required all 0",
               m_valid, level, full, ovf, m_addr, m_data);
    end
    @(negedge clk); rst = 1;
    for (int i = 0; i < 4; i++) begin
      m_ready = i[0];
      cyc();
      checks++;
      if (m_valid !== 1'b0 || level !== '0) begin
        errors++;
        $display("FAIL idle_ready_toggle: got valid=%b level=%0d, required 0/0", m_valid, level);
      end
    end
    m_ready = 0;
  endtask

  task automatic test_single();
    push_one(3'd3, 32'h0000ABCD);
    checks++;
    if (m_valid !== 1'b1 || m_addr !== 3'd3 || m_data !== 32'h0000ABCD || level !== 3'd1) begin
      errors++;
      $display("FAIL single_write: got valid=%b addr=%0d data=%h level=%0d, required 1/3/0000abcd/1",
               m_valid, m_addr, m_data, level);
    end
    m_ready = 1;
    cyc();
    m_ready = 0;
    checks++;
    if (m_valid !== 1'b0 || level !== 3'd0) begin
      errors++;
      $display("FAIL single_pop: got valid=%b level=%0d, required 0/0", m_valid, level);
    end
  endtask

  task automatic test_fill_overflow();
    for (int i = 1; i <= 5; i++) begin
      push_one(AW'(i), NB'(i));
      checks++;
      if (level !== LW'((i > FD) ? FD : i)) begin
        errors++;
        $display("FAIL fill_level_%0d: got %0d, required %0d", i, level, (i > FD) ? FD : i);
      end
    end
    checks++;
    if (full !== 1'b1 || ovf !== 1'b1) begin
      errors++;
      $display("FAIL overflow_flags: got full=%b ovf=%b, required 1/1", full, ovf);
    end
    m_ready = 1;
    for (int i = 1; i <= 4; i++) begin
      checks++;
      if (m_valid !== 1'b1 || m_data !== NB'(i)) begin
        errors++;
        $display("FAIL overflow_order_%0d: got valid=%b data=%0d, required 1/%0d", i, m_valid, m_data, i);
      end
      cyc();
    end
    m_ready = 0;
    checks++;
    if (m_valid !== 1'b0 || ovf !== 1'b1) begin
      errors++;
      $display("FAIL overflow_drained: got valid=%b ovf=%b, required 0/1 (value 5 must be dropped)", m_valid, ovf);
    end
    ovf_clr = 1;
    cyc();
    ovf_clr = 0;
    checks++;
    if (ovf !== 1'b0) begin
      errors++;
      $display("FAIL ovf_clear: got %b, required 0", ovf);
    end
  endtask

  task automatic test_full_push_pop();
    logic [NB-1:0] exp_seq [4];
    for (int i = 1; i <= 4; i++) push_one(3'd1, NB'(i));
    out_en = 1; addr_out = 3'd2; data_out = 32'd9; m_ready = 1;
    cyc();
    out_en = 0; m_ready = 0;
    checks++;
    if (ovf !== 1'b0 || level !== 3'd4 || full !== 1'b1 || m_data !== 32'd2) begin
      errors++;
      $display("FAIL full_push_pop: got ovf=%b level=%0d full=%b head=%0d, required 0/4/1/2",
               ovf, level, full, m_data);
    end
    exp_seq[0] = 2; exp_seq[1] = 3; exp_seq[2] = 4; exp_seq[3] = 9;
    m_ready = 1;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (m_valid !== 1'b1 || m_data !== exp_seq[i]) begin
        errors++;
        $display("FAIL full_push_pop_order_%0d: got valid=%b data=%0d, required 1/%0d",
                 i, m_valid, m_data, exp_seq[i]);
      end
      cyc();
    end
    m_ready = 0;
    checks++;
    if (m_valid !== 1'b0 || level !== 3'd0) begin
      errors++;
      $display("FAIL full_push_pop_empty: got valid=%b level=%0d, required 0/0", m_valid, level);
    end
  endtask

  task automatic test_wrap_stream();
    m_ready = 1;
    for (int i = 0; i < 20; i++) begin
      out_en = 1; addr_out = AW'(i); data_out = NB'(i);
      cyc();
      checks++;
      if (m_valid !== 1'b1 || m_data !== NB'(i) || m_addr !== AW'(i) || level !== 3'd1) begin
        errors++;
        $display("FAIL stream_%0d: got valid=%b addr=%0d data=%0d level=%0d, required 1/%0d/%0d/1",
                 i, m_valid, m_addr, m_data, level, i % 8, i);
      end
    end
    out_en = 0;
    cyc();
    m_ready = 0;
    checks++;
    if (m_valid !== 1'b0 || level !== 3'd0) begin
      errors++;
      $display("FAIL stream_end: got valid=%b level=%0d, required 0/0", m_valid, level);
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 3; i++) push_one(3'd5, 32'hA0 + NB'(i));
    #2;
    rst = 0;
    model_reset();
    #1;
    checks++;
    if (m_valid !== 1'b0 || level !== '0 || full !== 1'b0 || m_data !== '0) begin
      errors++;
      $display("FAIL async_reset: got valid=%b level=%0d full=%b data=%h, required 0/0/0/0",
               m_valid, level, full, m_data);
    end
    repeat (2) cyc();
    @(negedge clk); rst = 1;
    push_one(3'd6, 32'h55);
    checks++;
    if (m_valid !== 1'b1 || m_data !== 32'h55 || m_addr !== 3'd6 || level !== 3'd1) begin
      errors++;
      $display("FAIL post_reset_first: got valid=%b addr=%0d data=%h level=%0d, required 1/6/55/1",
               m_valid, m_addr, m_data, level);
    end
    m_ready = 1;
    cyc();
    m_ready = 0;
  endtask

  task automatic test_random();
    logic [AW+NB-1:0] head;
    bit               ev;
    for (int n = 0; n < 400; n++) begin
      out_en   = ($urandom_range(0, 9) < 6);
      m_ready  = ($urandom_range(0, 9) < 4);
      ovf_clr  = ($urandom_range(0, 15) == 0);
      addr_out = AW'($urandom);
      data_out = $urandom;
      cyc();
      ev   = (mq.size() > 0);
      head = ev ? mq[0] : '0;
      checks++;
      if (m_valid !== ev || {m_addr, m_data} !== head || level !== LW'(mq.size()) ||
          full !== (mq.size() == FD) || ovf !== m_ovf) begin
        errors++;
        $display("FAIL random_%0d: got valid=%b addr=%0d data=%h level=%0d full=%b ovf=%b, required %b/%0d/%h/%0d/%b/%b",
                 n, m_valid, m_addr, m_data, level, full, ovf,
                 ev, head[NB +: AW], head[NB-1:0], mq.size(), (mq.size() == FD), m_ovf);
      end
    end
    idle_inputs();
  endtask

  initial begin
    rst = 0;
    idle_inputs();
    model_reset();
    test_reset();
    test_single();
    test_fill_overflow();
    test_full_push_pop();
    test_wrap_stream();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
